// File: rtl/b10_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : b10_serial_adder
// Description : Digit-serial adder for N-digit 10's-complement BCD integers.
//               Processes one digit per clock, least significant digit first.
//               Each operand is sign-extended to N+1 digits, so the sum never
//               overflows. Optional subtraction is enabled by defining the
//               macro B10_SUB_EN, which adds the 'sub' port.
// Revision    : 1.0 - initial release
// ============================================================================
module b10_serial_adder #(
    parameter int N = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [4*N-1:0]     a,
    input  logic [4*N-1:0]     b,
`ifdef B10_SUB_EN
    input  logic               sub,
`endif
    output logic [4*(N+1)-1:0] s,
    output logic               ready,
    output logic               done,
    output logic               err
);

    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam int SW = 4 * (N + 1);

    localparam logic [CW-1:0] c_last_digit = CW'(N);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Sign extension of a 10's-complement digit: 5..9 means negative
    function automatic logic [3:0] ext_digit(input logic [3:0] d);
        return (d >= 4'd5) ? 4'd9 : 4'd0;
    endfunction

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [SW-1:0] r_a;
    logic [SW-1:0] r_b;
    logic [SW-1:0] r_s;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_err;
    logic          w_sub_active;
    logic          w_err_in;
    logic          w_accept;
    logic [3:0]    w_bi;
    logic [4:0]    w_t;
    logic [3:0]    w_digit;
    logic          w_carry_out;

    assign w_accept = (r_state == c_idle) && start;

`ifdef B10_SUB_EN
    logic r_sub;

    // Operation select is latched with the operands so 'sub' may change freely
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end
    end

    assign w_sub_active = r_sub;
`else
    assign w_sub_active = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN for N+1 digits -> DONE for one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (start) w_next_state = c_run;
            c_run:   if (r_cnt == c_last_digit) w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Output decode
    always_comb begin
        ready = (r_state == c_idle);
        done  = (r_state == c_done);
    end

    // Flag any non-BCD digit in either operand at capture time
    always_comb begin
        w_err_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_err_in = 1'b1;
            end
        end
    end

    // One BCD digit slice: B is 9's-complemented after extension when subtracting
    always_comb begin
        w_bi        = w_sub_active ? (4'd9 - r_b[3:0]) : r_b[3:0];
        w_t         = {1'b0, r_a[3:0]} + {1'b0, w_bi} + {4'd0, r_carry};
        w_carry_out = (w_t > 5'd9);
        w_digit     = w_carry_out ? 4'(w_t - 5'd10) : w_t[3:0];
    end

    // Datapath: operands are held pre-extended and shifted right one digit
    // per RUN cycle; the sum shifts in from the top so that after N+1 digits
    // digit i sits at s[4i+3:4i].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= {ext_digit(a[4*N-1 -: 4]), a};
            r_b     <= {ext_digit(b[4*N-1 -: 4]), b};
            r_cnt   <= '0;
`ifdef B10_SUB_EN
            r_carry <= sub;
`else
            r_carry <= 1'b0;
`endif
            r_err   <= w_err_in;
        end else if (r_state == c_run) begin
            r_s     <= {w_digit, r_s[SW-1:4]};
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign s   = r_s;
    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_b10_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_b10_serial_adder
// Description : Scoreboard bench for b10_serial_adder (N=4). Stimulus pushes
//               hand-computed results; a monitor pops and compares on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b10_serial_adder;

    localparam int N = 4;

    typedef struct {
        logic [19:0] s;
        logic        err;
        logic        chk_s;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [19:0] s;
    logic        ready;
    logic        done;
    logic        err;

    exp_t sb[$];
    int   checks;
    int   errors;

    b10_serial_adder #(.N(N)) dut (
        .clock (clk),
        .reset (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef B10_SUB_EN
        .sub   (sub),
`endif
        .s     (s),
        .ready (ready),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with s=%h, required no pending result", s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_s) begin
                    checks++;
                    if (s !== e.s) begin
                        errors++;
                        $display("FAIL %s s: got %h, required %h", e.name, s, e.s);
                    end
                end
                checks++;
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL %s err: got %b, required %b", e.name, err, e.err);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic wait_ready(input string nm);
        int k;
        for (k = 0; k < 50; k++) begin
            if (ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout: ready=%b, required 1", nm, ready);
        end
    endtask

    // Issue one operation, optionally disturbing it with a start during RUN,
    // and check that done rises exactly 5 edges after the capture edge.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsub,
                          input logic [19:0] es, input logic eerr, input logic chk_s,
                          input logic disturb, input string nm);
        exp_t e;
        int   k;
        wait_ready(nm);
        e.s = es; e.err = eerr; e.chk_s = chk_s; e.name = nm;
        sb.push_back(e);
        a = ta; b = tb_v; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'h9999; b = 16'h9999; sub = ~tsub;
        for (k = 1; k <= 20; k++) begin
            if (disturb && k == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) break;
        end
        check({nm, " latency"}, k, 5);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'd0, ready}, 1);
        check("reset done",  {31'd0, done},  0);
        check("reset err",   {31'd0, err},   0);
        check("reset s",     {12'd0, s},     0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'h0012, 16'h0034, 1'b0, 20'h00046, 1'b0, 1'b1, 1'b0, "add_0012_0034");
        run_op(16'h4999, 16'h0001, 1'b0, 20'h05000, 1'b0, 1'b1, 1'b0, "add_4999_0001");
        run_op(16'h5000, 16'h9999, 1'b0, 20'h94999, 1'b0, 1'b1, 1'b0, "add_5000_9999");
        run_op(16'h1234, 16'h5678, 1'b0, 20'h96912, 1'b0, 1'b1, 1'b0, "add_1234_5678");
        run_op(16'h9999, 16'h9999, 1'b0, 20'h99998, 1'b0, 1'b1, 1'b0, "add_9999_9999");
`ifdef B10_SUB_EN
        run_op(16'h0000, 16'h0001, 1'b1, 20'h99999, 1'b0, 1'b1, 1'b0, "sub_0000_0001");
        run_op(16'h0100, 16'h0250, 1'b1, 20'h99850, 1'b0, 1'b1, 1'b0, "sub_0100_0250");
`endif
        run_op(16'h0012, 16'h0034, 1'b0, 20'h00046, 1'b0, 1'b1, 1'b1, "ignored_start");
        run_op(16'h00A0, 16'h0000, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b0, "err_00A0");
        run_op(16'h0001, 16'h0001, 1'b0, 20'h00002, 1'b0, 1'b1, 1'b0, "after_err");

        // Reset in the middle of RUN: immediate IDLE, cleared result, no done
        wait_ready("mid_reset");
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_reset ready", {31'd0, ready}, 1);
        check("mid_reset s",     {12'd0, s},     0);
        check("mid_reset done",  {31'd0, done},  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            logic saw_done;
            saw_done = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) saw_done = 1'b1;
            end
            check("mid_reset no_done", {31'd0, saw_done}, 0);
        end

        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
